// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the registered decode stage.
// Register/immediate fields are sized for the widest supported REG_ADDR_W (8) and sliced by users.
package ctrl_pkg;

  localparam int REG_ADDR_MAX_W = 8;
  localparam int IMM_MAX_W      = 2*REG_ADDR_MAX_W - 1;

  localparam logic [1:0] PFX_AND  = 2'b00;
  localparam logic [1:0] PFX_ADD  = 2'b01;
  localparam logic [2:0] PFX_SET  = 3'b110;

  localparam logic [4:0] OP_SLT   = 5'b10000;
  localparam logic [4:0] OP_HALT  = 5'b10001;
  localparam logic [4:0] OP_LOAD  = 5'b10010;
  localparam logic [4:0] OP_STORE = 5'b10011;
  localparam logic [4:0] OP_ABS   = 5'b10100;
  localparam logic [4:0] OP_SEQ   = 5'b10101;
  localparam logic [4:0] OP_BRB   = 5'b10110;
  localparam logic [4:0] OP_RSVD  = 5'b10111;
  localparam logic [4:0] OP_SLL   = 5'b11100;
  localparam logic [4:0] OP_SRL   = 5'b11101;
  localparam logic [4:0] OP_BRF   = 5'b11110;
  localparam logic [4:0] OP_SUB   = 5'b11111;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_SRL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_ABS = 4'b0110,
    ALU_SEQ = 4'b0111,
    ALU_SET = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT_DRAIN,
    ST_DONE
  } fsm_state_e;

  typedef logic [REG_ADDR_MAX_W-1:0] reg_addr_t;
  typedef logic [IMM_MAX_W-1:0]      imm_t;

  typedef struct packed {
    alu_op_e   alu;
    reg_addr_t rs_addr;
    reg_addr_t rt_addr;
    reg_addr_t write_addr;
    imm_t      immediate;
    logic      regwrite;
    logic      write_data_control;
    logic      cb_write;
    logic      memwrite;
    logic      memread;
    logic      branchb;
    logic      branchf;
    logic      uses_rs;
    logic      uses_rt;
    logic      halt;
    logic      illegal;
  } ctrl_bundle_t;

  // A bubble keeps the operand fields of the last bundle but must never act.
  function automatic ctrl_bundle_t clear_strobes(input ctrl_bundle_t b);
    ctrl_bundle_t r;
    r                    = b;
    r.regwrite           = 1'b0;
    r.write_data_control = 1'b0;
    r.cb_write           = 1'b0;
    r.memwrite           = 1'b0;
    r.memread            = 1'b0;
    r.branchb            = 1'b0;
    r.branchf            = 1'b0;
    r.uses_rs            = 1'b0;
    r.uses_rt            = 1'b0;
    r.halt               = 1'b0;
    r.illegal            = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction decoder: every field has a zero default,
// so opcodes only assign what they actually use.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ACC_REG    = 7,
  parameter int CMP_REG    = 6,
  parameter int SUB_RS     = 2,
  parameter int SUB_RT     = 5,
  localparam int INSTR_W   = 2*REG_ADDR_W + 2
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               cb,
  output ctrl_bundle_t       bundle
);

  logic [4:0]            op;
  logic [REG_ADDR_W-1:0] reg_f;
  logic [REG_ADDR_W-1:0] hi_f;

  assign op    = instr[INSTR_W-1 -: 5];
  assign reg_f = instr[REG_ADDR_W-1:0];
  assign hi_f  = instr[2*REG_ADDR_W-1:REG_ADDR_W];

  always_comb begin
    bundle     = '0;
    bundle.alu = ALU_AND;
    if (op[4:3] == PFX_AND || op[4:3] == PFX_ADD) begin
      bundle.alu        = (op[4:3] == PFX_ADD) ? ALU_ADD : ALU_AND;
      bundle.write_addr = reg_addr_t'(hi_f);
      bundle.rs_addr    = reg_addr_t'(reg_f);
      bundle.rt_addr    = reg_addr_t'(ACC_REG);
      bundle.regwrite   = 1'b1;
      bundle.uses_rs    = 1'b1;
      bundle.uses_rt    = 1'b1;
    end else if (op[4:2] == PFX_SET) begin
      bundle.alu        = ALU_SET;
      bundle.immediate  = imm_t'(instr[INSTR_W-4:0]);
      bundle.write_addr = reg_addr_t'(ACC_REG);
      bundle.regwrite   = 1'b1;
    end else begin
      case (op)
        OP_SLL, OP_SRL: begin
          bundle.alu        = (op == OP_SRL) ? ALU_SRL : ALU_SLL;
          bundle.write_addr = reg_addr_t'(reg_f);
          bundle.rs_addr    = reg_addr_t'(reg_f);
          bundle.rt_addr    = reg_addr_t'(ACC_REG);
          bundle.regwrite   = 1'b1;
          bundle.uses_rs    = 1'b1;
          bundle.uses_rt    = 1'b1;
        end
        OP_BRF, OP_BRB: begin
          bundle.alu     = ALU_ADD;
          bundle.rs_addr = reg_addr_t'(reg_f);
          bundle.branchf = (op == OP_BRF) & cb;
          bundle.branchb = (op == OP_BRB) & cb;
          bundle.uses_rs = 1'b1;
        end
        OP_SUB: begin
          bundle.alu        = ALU_SUB;
          bundle.rs_addr    = reg_addr_t'(SUB_RS);
          bundle.rt_addr    = reg_addr_t'(SUB_RT);
          bundle.write_addr = reg_addr_t'(reg_f);
          bundle.regwrite   = 1'b1;
          bundle.uses_rs    = 1'b1;
          bundle.uses_rt    = 1'b1;
        end
        OP_SLT: begin
          bundle.alu      = ALU_SLT;
          bundle.rs_addr  = reg_addr_t'(CMP_REG);
          bundle.rt_addr  = reg_addr_t'(ACC_REG);
          bundle.cb_write = 1'b1;
          bundle.uses_rs  = 1'b1;
          bundle.uses_rt  = 1'b1;
        end
        OP_HALT: bundle.halt = 1'b1;
        OP_LOAD: begin
          bundle.alu                = ALU_ADD;
          bundle.write_addr         = reg_addr_t'(reg_f);
          bundle.rt_addr            = reg_addr_t'(ACC_REG);
          bundle.memread            = 1'b1;
          bundle.write_data_control = 1'b1;
          bundle.regwrite           = 1'b1;
          bundle.uses_rt            = 1'b1;
        end
        OP_STORE: begin
          bundle.alu      = ALU_ADD;
          bundle.rs_addr  = reg_addr_t'(reg_f);
          bundle.rt_addr  = reg_addr_t'(ACC_REG);
          bundle.memwrite = 1'b1;
          bundle.uses_rs  = 1'b1;
          bundle.uses_rt  = 1'b1;
        end
        OP_ABS: begin
          bundle.alu        = ALU_ABS;
          bundle.write_addr = reg_addr_t'(reg_f);
          bundle.rs_addr    = reg_addr_t'(reg_f);
          bundle.regwrite   = 1'b1;
          bundle.uses_rs    = 1'b1;
        end
        OP_SEQ: begin
          bundle.alu      = ALU_SEQ;
          bundle.rs_addr  = reg_addr_t'(reg_f);
          bundle.rt_addr  = reg_addr_t'(ACC_REG);
          bundle.cb_write = 1'b1;
          bundle.uses_rs  = 1'b1;
          bundle.uses_rt  = 1'b1;
        end
        default: bundle.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: valid/ready handshake, load-use interlock,
// branch flush and the RUN -> HALT_DRAIN -> DONE halt sequence.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ACC_REG    = 7,
  parameter int CMP_REG    = 6,
  parameter int SUB_RS     = 2,
  parameter int SUB_RT     = 5,
  parameter int LOAD_LAT   = 1,
  localparam int INSTR_W   = 2*REG_ADDR_W + 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  instr_valid_i,
  input  logic [INSTR_W-1:0]    instr_i,
  output logic                  instr_ready_o,
  input  logic                  cb_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [3:0]            alucontrol_o,
  output logic [REG_ADDR_W-1:0] rs_addr_o,
  output logic [REG_ADDR_W-1:0] rt_addr_o,
  output logic [REG_ADDR_W-1:0] write_addr_o,
  output logic [INSTR_W-4:0]    immediate_o,
  output logic                  regwrite_o,
  output logic                  write_data_control_o,
  output logic                  CBwrite_o,
  output logic                  memwrite_o,
  output logic                  memread_o,
  output logic                  branchb_o,
  output logic                  branchf_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  ctrl_bundle_t dec;
  ctrl_bundle_t bundle_q;
  fsm_state_e   state;
  logic         valid_q;
  logic         illegal_q;
  logic         done_q;
  logic [1:0]   bubble_cnt;
  logic         hazard;
  logic         accept;
  logic         unused_bundle;

  ctrl_decode_comb #(
    .REG_ADDR_W(REG_ADDR_W),
    .ACC_REG   (ACC_REG),
    .CMP_REG   (CMP_REG),
    .SUB_RS    (SUB_RS),
    .SUB_RT    (SUB_RT)
  ) u_decode (
    .instr (instr_i),
    .cb    (cb_i),
    .bundle(dec)
  );

  // bundle_q.memread is only ever set while the registered bundle is a live load.
  assign hazard = instr_valid_i & bundle_q.memread &
                  ((dec.uses_rs & (dec.rs_addr == bundle_q.write_addr)) |
                   (dec.uses_rt & (dec.rt_addr == bundle_q.write_addr)));

  assign instr_ready_o = (state == ST_RUN) &
                         (flush_i | ((bubble_cnt == 2'd0) & ~hazard));
  assign accept        = instr_valid_i & instr_ready_o;

  // One block owns the bundle register, the interlock counter and the halt FSM;
  // the defaults turn every cycle into a bubble unless an instruction issues.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= ST_RUN;
      valid_q    <= 1'b0;
      bundle_q   <= '0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
      bubble_cnt <= 2'd0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      bundle_q  <= clear_strobes(bundle_q);
      case (state)
        ST_RUN: begin
          if (flush_i) begin
            bubble_cnt <= 2'd0;
          end else if (accept) begin
            if (dec.illegal) begin
              illegal_q <= 1'b1;
            end else begin
              bundle_q <= dec;
              valid_q  <= 1'b1;
              if (dec.halt) state <= ST_HALT_DRAIN;
            end
          end else if (bubble_cnt != 2'd0) begin
            bubble_cnt <= bubble_cnt - 2'd1;
          end else if (hazard) begin
            bubble_cnt <= 2'(LOAD_LAT - 1);
          end
        end
        ST_HALT_DRAIN: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        default: done_q <= 1'b1;
      endcase
    end
  end

  assign valid_o              = valid_q;
  assign alucontrol_o         = bundle_q.alu;
  assign rs_addr_o            = bundle_q.rs_addr[REG_ADDR_W-1:0];
  assign rt_addr_o            = bundle_q.rt_addr[REG_ADDR_W-1:0];
  assign write_addr_o         = bundle_q.write_addr[REG_ADDR_W-1:0];
  assign immediate_o          = bundle_q.immediate[INSTR_W-4:0];
  assign regwrite_o           = bundle_q.regwrite;
  assign write_data_control_o = bundle_q.write_data_control;
  assign CBwrite_o            = bundle_q.cb_write;
  assign memwrite_o           = bundle_q.memwrite;
  assign memread_o            = bundle_q.memread;
  assign branchb_o            = bundle_q.branchb;
  assign branchf_o            = bundle_q.branchf;
  assign done_o               = done_q;
  assign illegal_o            = illegal_q;
  assign unused_bundle        = ^bundle_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: an 8-bit instance (REG_ADDR_W=3)
// plus a 10-bit instance (REG_ADDR_W=4) for the wide set-immediate case.
module tb_ctrl_decode_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic cb = 1'b0;
  logic flush = 1'b0;

  logic instr_ready, valid, regwrite, wdc, cbwrite, memwrite, memread, branchb, branchf, done, illegal;
  logic [3:0] alucontrol;
  logic [2:0] rs_addr, rt_addr, write_addr;
  logic [4:0] immediate;

  logic valid4 = 1'b0;
  logic [9:0] instr4 = 10'h000;
  logic ready4, valid4_o, regwrite4, wdc4, cbwrite4, memwrite4, memread4, branchb4, branchf4, done4, illegal4;
  logic [3:0] alucontrol4;
  logic [3:0] rs4, rt4, wa4;
  logic [6:0] imm4;

  int assert_count = 0;
  int fail_count = 0;

  always #5 clock = ~clock;

  ctrl_decode_pipe dut (
    .clock_i(clock), .reset_i(reset), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(instr_ready), .cb_i(cb), .flush_i(flush), .valid_o(valid),
    .alucontrol_o(alucontrol), .rs_addr_o(rs_addr), .rt_addr_o(rt_addr),
    .write_addr_o(write_addr), .immediate_o(immediate), .regwrite_o(regwrite),
    .write_data_control_o(wdc), .CBwrite_o(cbwrite), .memwrite_o(memwrite),
    .memread_o(memread), .branchb_o(branchb), .branchf_o(branchf),
    .done_o(done), .illegal_o(illegal)
  );

  ctrl_decode_pipe #(.REG_ADDR_W(4)) dut4 (
    .clock_i(clock), .reset_i(reset), .instr_valid_i(valid4), .instr_i(instr4),
    .instr_ready_o(ready4), .cb_i(cb), .flush_i(flush), .valid_o(valid4_o),
    .alucontrol_o(alucontrol4), .rs_addr_o(rs4), .rt_addr_o(rt4),
    .write_addr_o(wa4), .immediate_o(imm4), .regwrite_o(regwrite4),
    .write_data_control_o(wdc4), .CBwrite_o(cbwrite4), .memwrite_o(memwrite4),
    .memread_o(memread4), .branchb_o(branchb4), .branchf_o(branchf4),
    .done_o(done4), .illegal_o(illegal4)
  );

  // Drive one cycle of inputs just after the falling edge; registered outputs
  // then still show what the previous cycle's inputs produced.
  task automatic applyStimulus(input logic v, input logic [7:0] ins, input logic c, input logic f);
    @(negedge clock);
    instr_valid = v;
    instr = ins;
    cb = c;
    flush = f;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {regwrite, wdc, cbwrite, memwrite, memread, branchb, branchf};
  endfunction

  initial begin
    // reset
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_strobes", strobes(), 0);
    checkOutput("rst_fields", {alucontrol, rs_addr, rt_addr, write_addr, immediate}, 0);
    checkOutput("rst_ready4", ready4, 1);
    reset = 1'b0;

    // add r3,r2
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("add_ready", instr_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("add_valid", valid, 1);
    checkOutput("add_alu", alucontrol, 4'b0001);
    checkOutput("add_wa", write_addr, 3);
    checkOutput("add_rs", rs_addr, 2);
    checkOutput("add_rt", rt_addr, 7);
    checkOutput("add_strobes", strobes(), 7'b1000000);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle_valid", valid, 0);
    checkOutput("idle_strobes", strobes(), 0);

    // load r4 then and r1,r4: one bubble
    applyStimulus(1'b1, 8'h94, 1'b0, 1'b0);
    checkOutput("load_ready", instr_ready, 1);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0);
    checkOutput("load_valid", valid, 1);
    checkOutput("load_wa", write_addr, 4);
    checkOutput("load_strobes", strobes(), 7'b1100100);
    checkOutput("stall_ready", instr_ready, 0);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0);
    checkOutput("bubble_valid", valid, 0);
    checkOutput("bubble_strobes", strobes(), 0);
    checkOutput("resume_ready", instr_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("and_valid", valid, 1);
    checkOutput("and_alu", alucontrol, 4'b0000);
    checkOutput("and_rs", rs_addr, 4);
    checkOutput("and_wa", write_addr, 1);
    checkOutput("and_strobes", strobes(), 7'b1000000);

    // branchf r1 with cb=1 then cb=0
    applyStimulus(1'b1, 8'hF1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0);
    checkOutput("brf1_valid", valid, 1);
    checkOutput("brf1_strobes", strobes(), 7'b0000001);
    checkOutput("brf1_rs", rs_addr, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("brf0_valid", valid, 1);
    checkOutput("brf0_strobes", strobes(), 0);

    // reserved opcode
    applyStimulus(1'b1, 8'hB8, 1'b0, 1'b0);
    checkOutput("rsvd_ready", instr_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rsvd_illegal", illegal, 1);
    checkOutput("rsvd_valid", valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rsvd_pulse_end", illegal, 0);

    // halt with flush is discarded
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b1);
    checkOutput("hflush_ready", instr_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hflush_valid", valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hflush_done", done, 0);
    checkOutput("hflush_run", instr_ready, 1);

    // flush overrides an interlock
    applyStimulus(1'b1, 8'h94, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b1);
    checkOutput("iflush_ready", instr_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("iflush_valid", valid, 0);
    checkOutput("iflush_strobes", strobes(), 0);

    // halt then DONE despite valid instructions
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    checkOutput("halt_ready", instr_ready, 1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("halt_valid", valid, 1);
    checkOutput("halt_strobes", strobes(), 0);
    checkOutput("drain_ready", instr_ready, 0);
    checkOutput("drain_done", done, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
      checkOutput("done_flag", done, 1);
      checkOutput("done_ready", instr_ready, 0);
      checkOutput("done_valid", valid, 0);
    end
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rerst_done", done, 0);
    checkOutput("rerst_ready", instr_ready, 1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rerst_valid", valid, 1);

    // REG_ADDR_W=4 set immediate 0x7F
    @(negedge clock);
    valid4 = 1'b1;
    instr4 = 10'h37F;
    #1;
    checkOutput("set4_ready", ready4, 1);
    @(negedge clock);
    valid4 = 1'b0;
    #1;
    checkOutput("set4_valid", valid4_o, 1);
    checkOutput("set4_imm", imm4, 7'h7F);
    checkOutput("set4_wa", wa4, 7);
    checkOutput("set4_alu", alucontrol4, 4'b1000);
    checkOutput("set4_regwrite", regwrite4, 1);
    checkOutput("set4_others", {wdc4, cbwrite4, memwrite4, memread4, branchb4, branchf4, done4, illegal4}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
